// File: rtl/mul_share_arbiter_if.sv
// mul_share_arbiter_if
//   Bundles the requester-side handshake, the operand buses and the result
//   return bus of mul_share_arbiter.
//   master : requester side  (drives issue_en, req_valid, req_a, req_b)
//   slave  : arbiter side    (drives req_ready, res_valid, res_id, res_data, busy)
//   req_a packs requester i at [11i+10:11i], req_b at [8i+7:8i].
interface mul_share_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic                   issue_en;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*11-1:0]    req_a;
    logic [N_REQ*8-1:0]     req_b;
    logic [N_REQ-1:0]       res_valid;
    logic [IDW-1:0]         res_id;
    logic signed [18:0]     res_data;
    logic                   busy;

    modport master (
        output issue_en, req_valid, req_a, req_b,
        input  req_ready, res_valid, res_id, res_data, busy
    );

    modport slave (
        input  issue_en, req_valid, req_a, req_b,
        output req_ready, res_valid, res_id, res_data, busy
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// small_multiplier
//   11-bit signed x 8-bit signed -> 19-bit signed, LATENCY cycles from the
//   operands being sampled to the product appearing on p. Free-running, no
//   valid, no stall, no reset. LATENCY must be >= 2.
//   clk : clock
//   a/b : operands, sampled every rising edge
//   p   : product of the operands sampled LATENCY edges earlier
module small_multiplier #(
    parameter int LATENCY = 9
) (
    input  logic               clk,
    input  logic signed [10:0] a,
    input  logic signed [7:0]  b,
    output logic signed [18:0] p
);
    logic signed [10:0] a_q;
    logic signed [7:0]  b_q;
    logic signed [18:0] prod_d;
    logic signed [18:0] pipe_q [LATENCY-1];

    // True product always fits 19 bits, so a 19-bit multiply is exact.
    always_comb begin
        prod_d = 19'(a_q) * 19'(b_q);
    end

    always_ff @(posedge clk) begin
        a_q       <= a;
        b_q       <= b;
        pipe_q[0] <= prod_d;
        for (int i = 1; i < LATENCY - 1; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign p = pipe_q[LATENCY-2];
endmodule

// mul_share_arbiter
//   Round-robin front end sharing one small_multiplier among N_REQ
//   requesters. At most one operation is accepted per cycle; a {valid, id}
//   tag travels alongside the multiplier pipeline so each product is routed
//   back to the requester that issued it, MUL_LATENCY cycles after accept.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of mul_share_arbiter_if
//              issue_en gates new grants; req_valid/req_ready handshake;
//              req_a/req_b packed operands; res_valid/res_id/res_data
//              return bus (no backpressure); busy = ops outstanding.
module mul_share_arbiter #(
    parameter int N_REQ       = 4,
    parameter int MUL_LATENCY = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    mul_share_arbiter_if.slave    bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(MUL_LATENCY + 1);
    localparam logic [IDW:0] NQ = (IDW+1)'(N_REQ);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    // Per-requester operand slices.
    logic [N_REQ-1:0][10:0] a_arr;
    logic [N_REQ-1:0][7:0]  b_arr;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = bus.req_a[11*i +: 11];
        assign b_arr[i] = bus.req_b[8*i +: 8];
    end

    logic [IDW-1:0]               ptr_q, ptr_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    tag_t [MUL_LATENCY-1:0]       tag_q, tag_d;

    logic [N_REQ-1:0]   cand;
    logic               acc;
    logic [IDW-1:0]     gnt_id;
    logic [IDW:0]       sum;
    logic [IDW-1:0]     idx;
    logic               ret;
    tag_t               last;
    logic signed [10:0] mul_a;
    logic signed [7:0]  mul_b;
    logic signed [18:0] mul_p;

    // Arbitration: scan from ptr with wrap; first candidate wins. rst is
    // folded into the candidate mask so nothing is accepted in a reset cycle.
    always_comb begin
        cand   = bus.req_valid & {N_REQ{bus.issue_en & ~rst}};
        acc    = 1'b0;
        gnt_id = '0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum >= NQ) begin
                sum = sum - NQ;
            end
            idx = sum[IDW-1:0];
            if (!acc && cand[idx]) begin
                acc    = 1'b1;
                gnt_id = idx;
            end
        end
    end

    // Idle cycles feed zeros so the multiplier never sees stale operands.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (acc) begin
            mul_a = a_arr[gnt_id];
            mul_b = b_arr[gnt_id];
        end
    end

    small_multiplier #(
        .LATENCY (MUL_LATENCY)
    ) u_mul (
        .clk (clk),
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p)
    );

    assign last = tag_q[MUL_LATENCY-1];
    assign ret  = last.vld;

    always_comb begin
        ptr_d = ptr_q;
        if (acc) begin
            ptr_d = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1);
        end

        // Tag stage 0 is sampled at the same edge as the multiplier
        // operands, so the last stage lines up with mul_p.
        tag_d[0].vld = acc;
        tag_d[0].id  = gnt_id;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        unique case ({acc, ret})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Clearing the tag valids on reset drops in-flight ops even though the
    // multiplier pipeline keeps their products.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            tag_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            tag_q <= tag_d;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.res_valid = '0;
        bus.res_id    = '0;
        bus.res_data  = '0;
        if (acc) begin
            bus.req_ready[gnt_id] = 1'b1;
        end
        if (ret) begin
            bus.res_valid[last.id] = 1'b1;
            bus.res_id             = last.id;
            bus.res_data           = mul_p;
        end
        bus.busy = (cnt_q != '0) | acc;
    end
endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;
    localparam int N   = 4;
    localparam int LAT = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_share_arbiter_if #(.N_REQ(N)) bus ();

    mul_share_arbiter #(
        .N_REQ       (N),
        .MUL_LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [N-1:0]       tv;
    logic               ten;
    logic signed [10:0] ta  [N];
    logic signed [7:0]  tbv [N];

    assign bus.req_valid = tv;
    assign bus.issue_en  = ten;
    for (genvar i = 0; i < N; i++) begin : g_pack
        assign bus.req_a[11*i +: 11] = ta[i];
        assign bus.req_b[8*i +: 8]   = tbv[i];
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en;

    // Sampled outputs of the current cycle.
    logic [N-1:0]       s_rdy, s_rv;
    logic [1:0]         s_id;
    logic signed [18:0] s_dat;
    logic               s_busy;

    // Reference model: expected results queued with their due cycle.
    typedef struct {
        int due;
        int id;
        int prod;
    } exp_t;
    exp_t q[$];
    int   ptr_m;
    bit   m_acc;
    int   m_g;
    int   wait_c [N];

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_check();
        logic [N-1:0] cand, er;
        cand  = rst ? '0 : (ten ? tv : '0);
        m_acc = 1'b0;
        m_g   = 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr_m + k) % N;
            if (!m_acc && cand[j]) begin
                m_acc = 1'b1;
                m_g   = j;
            end
        end
        if (chk_en) begin
            er = '0;
            if (m_acc) er[m_g] = 1'b1;
            chk("ready", s_rdy, er);
            if (q.size() > 0 && q[0].due == cyc) begin
                er = '0;
                er[q[0].id] = 1'b1;
                chk("res_valid", s_rv, er);
                chk("res_id", s_id, q[0].id);
                chk("res_data", s_dat, q[0].prod);
            end else begin
                chk("res_valid_idle", s_rv, 0);
                chk("res_id_idle", s_id, 0);
                chk("res_data_idle", s_dat, 0);
            end
            chk("busy", s_busy, (q.size() > 0 || m_acc) ? 1 : 0);
        end
    endtask

    task automatic model_update();
        exp_t e;
        if (rst) begin
            q.delete();
            ptr_m = 0;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
            if (m_acc) begin
                e.due  = cyc + LAT;
                e.id   = m_g;
                e.prod = int'(ta[m_g]) * int'(tbv[m_g]);
                q.push_back(e);
                ptr_m = (m_g + 1) % N;
            end
        end
        // Fairness: while issue_en stays high, a valid requester is granted
        // within N cycles.
        for (int i = 0; i < N; i++) begin
            if (!rst && ten && tv[i]) begin
                if (m_acc && m_g == i) begin
                    if (chk_en) chk("starve", (wait_c[i] < N) ? 1 : 0, 1);
                    wait_c[i] = 0;
                end else begin
                    wait_c[i]++;
                end
            end else begin
                wait_c[i] = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        s_rdy  = bus.req_ready;
        s_rv   = bus.res_valid;
        s_id   = bus.res_id;
        s_dat  = bus.res_data;
        s_busy = bus.busy;
        model_check();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tv  = '0;
        ten = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        int id;
        int a;
        int b;
        int prod;
    } vec_t;
    vec_t vecs [7];

    initial begin
        #1_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{0, -1024, -128,  131072};
        vecs[1] = '{1,  1023, -128, -130944};
        vecs[2] = '{2, -1024,  127, -130048};
        vecs[3] = '{3,  1023,  127,  129921};
        vecs[4] = '{3,     0, -128,       0};
        vecs[5] = '{1,    -1,   -1,       1};
        vecs[6] = '{2,     1,   -1,      -1};

        rst = 1'b1; tv = '0; ten = 1'b1; chk_en = 1'b0; ptr_m = 0;
        for (int i = 0; i < N; i++) begin
            ta[i] = '0; tbv[i] = '0; wait_c[i] = 0;
        end
        step();
        chk_en = 1'b1;
        do_reset();

        // Reset together with valid: no accept; then reset state.
        rst = 1'b1; tv = '1;
        step();
        chk("rst_with_valid_rdy", s_rdy, 0);
        rst = 1'b0; tv = '0;
        step();
        chk("rst_rdy", s_rdy, 0);
        chk("rst_rv", s_rv, 0);
        chk("rst_id", s_id, 0);
        chk("rst_dat", s_dat, 0);
        chk("rst_busy", s_busy, 0);

        // Single op from requester 2.
        do_reset();
        tv = 4'b0100; ta[2] = -11'sd5; tbv[2] = 8'sd7;
        step();
        chk("single_rdy", s_rdy, 4'b0100);
        tv = '0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 9) begin
                chk("single_rv", s_rv, 4'b0100);
                chk("single_id", s_id, 2);
                chk("single_dat", s_dat, -35);
            end else begin
                chk("single_quiet", s_rv, 0);
            end
        end

        // Full contention.
        do_reset();
        for (int i = 0; i < N; i++) begin
            ta[i] = 11'(i + 1); tbv[i] = -8'sd3;
        end
        tv = '1;
        for (int c = 0; c <= 16; c++) begin
            step();
            if (c <= 7) chk("cont_gnt", s_rdy, 1 << (c % 4));
            if (c >= 9) begin
                chk("cont_id", s_id, (c - 9) % 4);
                chk("cont_dat", s_dat, -3 * ((c - 9) % 4 + 1));
            end
        end
        tv = '0;
        repeat (LAT + 2) step();

        // Table of operand extremes, one op per cycle, back to back.
        do_reset();
        for (int c = 0; c < 7 + LAT + 1; c++) begin
            tv = '0;
            if (c < 7) begin
                tv[vecs[c].id]  = 1'b1;
                ta[vecs[c].id]  = 11'(vecs[c].a);
                tbv[vecs[c].id] = 8'(vecs[c].b);
            end
            step();
            if (c < 7) chk("vec_rdy", s_rdy, 1 << vecs[c].id);
            if (c >= LAT && c - LAT < 7) begin
                chk("vec_id", s_id, vecs[c-LAT].id);
                chk("vec_dat", s_dat, vecs[c-LAT].prod);
            end
        end
        tv = '0;

        // Reset mid-flight.
        do_reset();
        ta[0] = 11'sd100; tbv[0] = 8'sd3;
        ta[1] = 11'sd7;   tbv[1] = -8'sd2;
        for (int c = 0; c <= 20; c++) begin
            tv  = (c <= 3) ? 4'b0001 : ((c == 7) ? 4'b0010 : 4'b0000);
            rst = (c == 5);
            step();
            if (c == 6) chk("rmf_busy", s_busy, 0);
            if (c == 7) chk("rmf_rdy", s_rdy, 4'b0010);
            if (c >= 6) begin
                if (c == 16) begin
                    chk("rmf_new_rv", s_rv, 4'b0010);
                    chk("rmf_new_dat", s_dat, -14);
                end else begin
                    chk("rmf_quiet", s_rv, 0);
                end
            end
        end
        rst = 1'b0; tv = '0;

        // issue_en gating.
        do_reset();
        tv = 4'b1010;
        ta[1] = 11'sd5;  tbv[1] = 8'sd5;
        ta[3] = -11'sd6; tbv[3] = 8'sd4;
        for (int c = 0; c <= 17; c++) begin
            ten = (c >= 5);
            step();
            if (m_acc) tv[m_g] = 1'b0;
            if (c < 5)   chk("gate_rdy", s_rdy, 0);
            if (c == 5)  chk("gate_first", s_rdy, 4'b0010);
            if (c == 6)  chk("gate_second", s_rdy, 4'b1000);
            if (c == 14) chk("gate_res1", s_dat, 25);
            if (c == 15) begin
                chk("gate_res2", s_dat, -24);
                chk("gate_busy_hi", s_busy, 1);
            end
            if (c == 16) chk("gate_busy_lo", s_busy, 0);
        end
        ten = 1'b1;

        // Random soak against the reference queue.
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            ten = ($urandom_range(0, 15) != 0);
            rst = ($urandom_range(0, 999) == 0);
            for (int i = 0; i < N; i++) begin
                if (!tv[i] && $urandom_range(0, 1) == 1) begin
                    tv[i]  = 1'b1;
                    ta[i]  = 11'($urandom);
                    tbv[i] = 8'($urandom);
                    if ($urandom_range(0, 7) == 0) begin
                        ta[i]  = ($urandom_range(0, 1) == 1) ? -11'sd1024 : 11'sd1023;
                        tbv[i] = ($urandom_range(0, 1) == 1) ? -8'sd128 : 8'sd127;
                    end
                end
            end
            step();
            if (m_acc) tv[m_g] = 1'b0;
        end
        rst = 1'b0; tv = '0;
        repeat (LAT + 2) step();
        chk("drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin front end that shares one `small_multiplier` instance (11-bit signed × 8-bit signed → 19-bit signed, 9-cycle fixed latency, no valid/stall) among `N_REQ` requesters, such as the per-object depth-scaling units in the render path. It accepts at most one operation per cycle via valid/ready handshakes and drives the operands into the multiplier. It carries a valid bit and requester ID alongside the multiplier pipeline, then returns each product to the requester that issued it.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `MUL_LATENCY`, 9: cycles from the multiplier input being sampled to its product appearing; must equal the instantiated multiplier's latency.
- `clk` input 1: system clock; all state on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `issue_en` input 1: when low, no new grants; in-flight operations still complete.
- `req_valid` input N_REQ: bit i = requester i has an operation.
- `req_ready` output N_REQ: bit i = requester i's operation accepted this cycle (one-hot or zero).
- `req_a` input N_REQ*11: signed 11-bit operand per requester; requester i at bits [11i+10:11i].
- `req_b` input N_REQ*8: signed 8-bit operand per requester; requester i at bits [8i+7:8i].
- `res_valid` output N_REQ: one-hot; bit i = `res_data` belongs to requester i this cycle.
- `res_id` output $clog2(N_REQ): index of the requester owning the current result; 0 when none.
- `res_data` output 19 signed: product a×b; 0 when `res_valid` is all zero.
- `busy` output 1: high while any accepted operation has not yet returned.

## Operation
- **Arbitration (combinational per cycle):**
  - Candidates are `req_valid & {N_REQ{issue_en & ~rst}}`.
  - Search order starts at round-robin pointer `ptr` and wraps modulo N_REQ.
  - The first candidate found wins; `req_ready` is one-hot on the winner.
- **Pointer:**
  - On an accept by requester g, `ptr` ← (g+1) mod N_REQ.
  - With no accept, `ptr` holds.
  - `ptr` resets to 0.
- **Requester rules:**
  - `req_valid` must not depend on `req_ready`.
  - Operands must be stable while `req_valid` is high and not yet accepted.
  - Ready may depend on valid.
- **Operand mux:**
  - With an accept, the winner's `req_a`/`req_b` drive the multiplier inputs.
  - Otherwise the multiplier inputs are driven to 0.
- **Tag pipeline:**
  - A MUL_LATENCY-deep shift register of {valid, id}.
  - Stage 0 loads {accept, winner id} on each edge; later stages shift every cycle unconditionally.
  - The final stage aligns exactly with the multiplier output.
- **Result outputs:**
  - `res_valid` = one-hot decode of the last stage when its valid bit is set, else 0.
  - `res_id` = last-stage id when valid, else 0.
  - `res_data` = multiplier output when valid, else 0.
- **Busy:**
  - `busy` = OR of all tag-stage valid bits, plus the current-cycle accept.
  - Implemented with an in-flight counter (0..MUL_LATENCY): +1 on accept, −1 on result, both in the same cycle = no change.
- **Arithmetic:** full-precision signed product; no saturation or rounding. Range is −1024×127 … −1024×−128 = +131072, which fits in 19 bits.
- **No backpressure on results:** requesters must take `res_valid` in the cycle it is asserted.

## Timing
- An operation accepted in cycle t (valid & ready high before edge t+1) returns with `res_valid` in cycle t+MUL_LATENCY (t+9 default).
- **Throughput:**
  - One accept per cycle aggregate.
  - Results return in issue order, one per cycle at most.
  - Under full contention each of the N_REQ requesters is served once every N_REQ cycles.
- **Reset (sampled high at an edge):**
  - Clears all tag valid bits, `ptr`, and the in-flight counter.
  - In the cycle after: `req_ready`=0, `res_valid`=0, `res_id`=0, `res_data`=0, `busy`=0.
  - Operations in flight when reset is asserted are discarded; no `res_valid` ever appears for them, even though the multiplier itself is not reset.
- **`rst` high in the same cycle as `req_valid`:** no accept; `req_ready`=0.
- **`issue_en` falling mid-stream:** grants stop that cycle; already-accepted operations still return on schedule; `busy` falls in the cycle after the last result.
- **Single requester valid continuously:** it is granted every cycle regardless of `ptr`.

## Test plan
- **Single op:** after reset, requester 2 presents a=−5, b=7 for one cycle in cycle 0.
  - `req_ready`=4'b0100 in cycle 0.
  - `res_valid`=4'b0100, `res_id`=2, `res_data`=−35 in cycle 9; all zero in every other cycle.
- **Full contention:** all four requesters valid continuously with a=i+1, b=−3.
  - Grants in cycles 0..7 go 0,1,2,3,0,1,2,3.
  - Results in cycles 9..16 are −3,−6,−9,−12 repeating, with matching `res_id`.
- **Extremes:** a=−1024, b=−128 → `res_data`=+131072. a=1023, b=−128 → −130944. a=−1024, b=127 → −130048.
- **Reset mid-flight:** issue back-to-back ops in cycles 0–3, assert `rst` in cycle 5 for one cycle.
  - No `res_valid` in cycles 6–20.
  - `busy`=0 from cycle 6.
  - A new op issued in cycle 7 returns in cycle 16.
- **`issue_en` gating:** hold `issue_en`=0 with requesters 1 and 3 valid for 5 cycles, then raise it.
  - No grants while `issue_en` is low.
  - Requester 1 is granted first (ptr=0), then 3.
  - `busy` drops one cycle after the second result.
- **Random soak:** random valid and operand streams, 10k cycles, checked against a reference queue.
  - Every accepted op returns exactly once, in order, with the correct id and product.
  - No requester waits more than N_REQ cycles while continuously valid and `issue_en`=1.
